// File: rtl/render_pkg.sv
// Shared state encoding, game-status codes, screen geometry and colours for block_renderer.
// BLOCK_RENDERER_HUD_EN adds the HUD state to the state enum.
package render_pkg;

`ifdef BLOCK_RENDERER_HUD_EN
  typedef enum logic [2:0] {ST_IDLE, ST_ERASE, ST_DRAW, ST_HUD, ST_CLEAR, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_ERASE, ST_DRAW, ST_CLEAR, ST_DONE} state_t;
`endif

  localparam logic [1:0] GS_START   = 2'b00;
  localparam logic [1:0] GS_PLAYING = 2'b01;
  localparam logic [1:0] GS_OVER    = 2'b10;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [2:0] BG_COL    = 3'b000;
  localparam logic [2:0] BLOCK_COL = 3'b110;
  localparam logic [2:0] OVER_COL  = 3'b100;
  localparam logic [2:0] HUD_COL   = 3'b010;

  localparam int HUD_W = 60;
  localparam int HUD_H = 2;

  // The reserved code behaves exactly like START.
  function automatic logic [1:0] norm_status(input logic [1:0] s);
    return (s == 2'b11) ? GS_START : s;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle sweep: col runs fastest, last flags the final cell.
// Shared by every sweeping state of block_renderer.
module rect_scanner #(
  parameter int CW = 8,
  parameter int RW = 7
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] width,
  input  logic [RW-1:0] height,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          active,
  output logic          last
);

  logic [CW-1:0] width_reg;
  logic [RW-1:0] height_reg;
  logic          col_end;

  assign col_end = (col == width_reg - CW'(1));
  assign last    = active && col_end && (row == height_reg - RW'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col        <= '0;
      row        <= '0;
      active     <= 1'b0;
      width_reg  <= '0;
      height_reg <= '0;
    end else if (start) begin
      col        <= '0;
      row        <= '0;
      active     <= 1'b1;
      width_reg  <= width;
      height_reg <= height;
    end else if (abort || last) begin
      col    <= '0;
      row    <= '0;
      active <= 1'b0;
    end else if (active) begin
      if (col_end) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/block_renderer.sv
// Turns block position/status into single-pixel frame-buffer writes (erase, draw, full clear).
// Define BLOCK_RENDERER_HUD_EN to add a score bar sweep after each draw.
module block_renderer
  import render_pkg::*;
#(
  parameter int         BLOCK_W      = 16,
  parameter int         BLOCK_H      = 8,
  parameter int         SCREEN_W     = SCR_W,
  parameter int         SCREEN_H     = SCR_H,
  parameter logic [2:0] BG_COLOUR    = BG_COL,
  parameter logic [2:0] BLOCK_COLOUR = BLOCK_COL,
  parameter logic [2:0] OVER_COLOUR  = OVER_COL
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sync,
  input  logic [7:0] x,
  input  logic [7:0] prev_x,
  input  logic [6:0] y,
  input  logic [3:0] score,
  input  logic [1:0] game_status,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state_reg;
  state_t     sweep_next;
  logic [1:0] status_reg;
  logic [1:0] status_now;
  logic       pending_reg;
  logic [7:0] x_reg;
  logic [7:0] prev_x_reg;
  logic [6:0] y_reg;
  logic [2:0] clear_colour_reg;

  logic       status_edge;
  logic       sync_ok;
  logic       accept;

  logic       scan_start;
  logic       scan_abort;
  logic [7:0] scan_w;
  logic [6:0] scan_h;
  logic [7:0] scan_col;
  logic [6:0] scan_row;
  logic       scan_active;
  logic       scan_last;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] px_col;
  logic [7:0] px_row;
  logic [2:0] px_colour;
  logic       px_active;
  logic       px_in_view;

  assign status_now  = norm_status(game_status);
  assign status_edge = (status_now != status_reg) &&
                       (status_now == GS_PLAYING || status_now == GS_OVER);
  assign sync_ok     = sync && (status_now == GS_PLAYING);
  assign accept      = (state_reg == ST_IDLE) && (sync || pending_reg) && (status_now == GS_PLAYING);

`ifndef BLOCK_RENDERER_HUD_EN
  logic unused_score;
  assign unused_score = ^score;
`endif

  rect_scanner #(.CW(8), .RW(7)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .abort  (scan_abort),
    .width  (scan_w),
    .height (scan_h),
    .col    (scan_col),
    .row    (scan_row),
    .active (scan_active),
    .last   (scan_last)
  );

  // Scanner reload: a status edge always wins, otherwise chain sweeps back-to-back.
  always_comb begin
    scan_start = 1'b0;
    scan_abort = 1'b0;
    scan_w     = 8'(BLOCK_W);
    scan_h     = 7'(BLOCK_H);
    sweep_next = ST_DONE;
    if (status_edge) begin
      scan_start = 1'b1;
      scan_w     = 8'(SCREEN_W);
      scan_h     = 7'(SCREEN_H);
    end else begin
      case (state_reg)
        ST_IDLE:  scan_start = accept;
        ST_ERASE: begin
          sweep_next = ST_DRAW;
          scan_start = scan_last;
        end
`ifdef BLOCK_RENDERER_HUD_EN
        ST_DRAW: begin
          sweep_next = ST_HUD;
          scan_start = scan_last;
          scan_w     = 8'(HUD_W);
          scan_h     = 7'(HUD_H);
        end
`endif
        default: sweep_next = ST_DONE;
      endcase
      if ((state_reg == ST_IDLE || state_reg == ST_DONE) && !scan_start)
        scan_abort = 1'b1;
    end
  end

  always_comb begin
    base_x    = x_reg;
    base_y    = y_reg;
    px_colour = BLOCK_COLOUR;
    px_active = 1'b0;
    case (state_reg)
      ST_ERASE: begin
        base_x    = prev_x_reg;
        px_colour = BG_COLOUR;
        px_active = scan_active;
      end
      ST_DRAW: px_active = scan_active;
`ifdef BLOCK_RENDERER_HUD_EN
      ST_HUD: begin
        base_x    = '0;
        base_y    = '0;
        px_colour = ({1'b0, scan_col} < {3'b000, score, 2'b00}) ? HUD_COL : BG_COLOUR;
        px_active = scan_active;
      end
`endif
      ST_CLEAR: begin
        base_x    = '0;
        base_y    = '0;
        px_colour = clear_colour_reg;
        px_active = scan_active;
      end
      default: px_active = 1'b0;
    endcase
  end

  // Widened sums so blocks hanging off the right or bottom edge clip instead of wrapping.
  assign px_col     = {1'b0, base_x} + {1'b0, scan_col};
  assign px_row     = {1'b0, base_y} + {1'b0, scan_row};
  assign px_in_view = (px_col < 9'(SCREEN_W)) && (px_row < 8'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg        <= ST_IDLE;
      status_reg       <= GS_START;
      pending_reg      <= 1'b0;
      x_reg            <= '0;
      prev_x_reg       <= '0;
      y_reg            <= '0;
      clear_colour_reg <= BG_COLOUR;
      vga_x            <= '0;
      vga_y            <= '0;
      colour           <= '0;
      plot             <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      status_reg <= status_now;
      plot       <= 1'b0;
      done       <= 1'b0;
      if (px_active) begin
        vga_x  <= px_col[7:0];
        vga_y  <= px_row[6:0];
        colour <= px_colour;
        plot   <= px_in_view;
      end
      if (status_edge) begin
        state_reg        <= ST_CLEAR;
        busy             <= 1'b1;
        pending_reg      <= 1'b0;
        plot             <= 1'b0;
        clear_colour_reg <= (status_now == GS_OVER) ? OVER_COLOUR : BG_COLOUR;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            pending_reg <= 1'b0;
            if (accept) begin
              x_reg      <= x;
              prev_x_reg <= prev_x;
              y_reg      <= y;
              busy       <= 1'b1;
              state_reg  <= (prev_x == x) ? ST_DRAW : ST_ERASE;
            end
          end
          ST_CLEAR: begin
            if (scan_last) begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
          // First DONE cycle shows the final pixel, second carries the done pulse.
          ST_DONE: begin
            if (sync_ok) pending_reg <= 1'b1;
            if (!done) begin
              done <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
          default: begin
            if (sync_ok) pending_reg <= 1'b1;
            if (scan_last) state_reg <= sweep_next;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_renderer.sv
// Directed bench for block_renderer (default build): reset, clears, erase/draw, skip, pending, clipping, preemption.
module tb_block_renderer;

  logic       clk = 1'b0;
  logic       resetn, sync;
  logic [7:0] x, prev_x;
  logic [6:0] y;
  logic [3:0] score;
  logic [1:0] game_status;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int passed = 0;
  int total  = 0;

  localparam int CAP = 20000;
  logic       cap_plot [CAP];
  logic [7:0] cap_x    [CAP];
  logic [6:0] cap_y    [CAP];
  logic [2:0] cap_col  [CAP];
  logic       cap_busy [CAP];
  logic       cap_done [CAP];

  always #10 clk = ~clk;

  block_renderer dut (
    .clk(clk), .resetn(resetn), .sync(sync), .x(x), .prev_x(prev_x), .y(y),
    .score(score), .game_status(game_status), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges; sync pulses at the listed indices, status change at st_idx,
  // new x/prev_x/y applied after the first edge. Entry i is sampled just after edge i.
  task automatic capture(input int n, input int s0, input int s1, input int s2, input int s3,
                         input int st_idx, input logic [1:0] st_val,
                         input logic [7:0] nx, input logic [7:0] npx, input logic [6:0] ny);
    for (int i = 0; i < n; i++) begin
      sync = (i == s0 || i == s1 || i == s2 || i == s3);
      if (i == st_idx) game_status = st_val;
      if (i == 1) begin
        x = nx; prev_x = npx; y = ny;
      end
      tick();
      cap_plot[i] = plot; cap_x[i] = vga_x; cap_y[i] = vga_y;
      cap_col[i] = colour; cap_busy[i] = busy; cap_done[i] = done;
    end
    sync = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; sync = 1'b0; x = '0; prev_x = '0; y = '0; score = '0; game_status = 2'b00;
    repeat (3) tick();
    total++; if (plot !== 1'b0) $display("FAIL reset_plot: got %0b want 0", plot); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
    total++; if (vga_x !== 8'd0) $display("FAIL reset_vga_x: got %0d want 0", vga_x); else passed++;
    total++; if (vga_y !== 7'd0) $display("FAIL reset_vga_y: got %0d want 0", vga_y); else passed++;
    total++; if (colour !== 3'd0) $display("FAIL reset_colour: got %0d want 0", colour); else passed++;
    resetn = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_clear_start();
    int plots = 0, bad = 0, dones = 0, first = -1;
    capture(19205, -1, -1, -1, -1, 0, 2'b01, 8'd0, 8'd0, 7'd0);
    for (int j = 0; j < 19205; j++) begin
      if (cap_done[j]) dones++;
      if (cap_plot[j]) begin
        if (first < 0) first = j;
        if (cap_x[j] !== 8'(plots % 160) || cap_y[j] !== 7'(plots / 160) || cap_col[j] !== 3'b000) bad++;
        plots++;
      end
    end
    total++; if (plots != 19200) $display("FAIL clear_count: got %0d want 19200", plots); else passed++;
    total++; if (bad != 0) $display("FAIL clear_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (first != 1) $display("FAIL clear_first: got idx %0d want 1", first); else passed++;
    total++; if (dones != 0) $display("FAIL clear_done: got %0d pulses want 0", dones); else passed++;
    total++; if (cap_busy[0] !== 1'b1 || cap_busy[19199] !== 1'b1)
      $display("FAIL clear_busy: got %0b/%0b want 1/1", cap_busy[0], cap_busy[19199]); else passed++;
    total++; if (cap_busy[19200] !== 1'b0) $display("FAIL clear_busy_fall: got %0b want 0", cap_busy[19200]); else passed++;
    $display("test_clear_start: %0d plots", plots);
  endtask

  task automatic test_move();
    int bad = 0, dones = 0, k, ex, ey;
    logic ep;
    logic [2:0] ec;
    prev_x = 8'd20; x = 8'd24; y = 7'd100;
    capture(300, 0, -1, -1, -1, -1, 2'b01, 8'd90, 8'd91, 7'd5);
    for (int j = 0; j < 300; j++) begin
      ep = 1'b0; ex = 0; ey = 0; ec = 3'b000;
      if (j >= 1 && j <= 128) begin
        k = j - 1; ep = 1'b1; ex = 20 + k % 16; ey = 100 + k / 16; ec = 3'b000;
      end else if (j >= 129 && j <= 256) begin
        k = j - 129; ep = 1'b1; ex = 24 + k % 16; ey = 100 + k / 16; ec = 3'b110;
      end
      if (cap_plot[j] !== ep) bad++;
      else if (ep && (cap_x[j] !== 8'(ex) || cap_y[j] !== 7'(ey) || cap_col[j] !== ec)) bad++;
      if (cap_done[j]) dones++;
    end
    total++; if (cap_plot[0] !== 1'b0 || cap_plot[1] !== 1'b1)
      $display("FAIL move_latency: got %0b%0b want 01", cap_plot[0], cap_plot[1]); else passed++;
    total++; if (bad != 0) $display("FAIL move_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (cap_done[257] !== 1'b1) $display("FAIL move_done_time: got %0b want 1", cap_done[257]); else passed++;
    total++; if (dones != 1) $display("FAIL move_done_count: got %0d want 1", dones); else passed++;
    total++; if (cap_busy[257] !== 1'b1 || cap_busy[258] !== 1'b0)
      $display("FAIL move_busy: got %0b%0b want 10", cap_busy[257], cap_busy[258]); else passed++;
    $display("test_move: erase 20 draw 24 row 100");
  endtask

  task automatic test_same_x_pending();
    int bad = 0, dones = 0, plots = 0, k, ex, ey;
    logic ep;
    prev_x = 8'd50; x = 8'd50; y = 7'd10;
    capture(320, 0, 40, 60, 80, -1, 2'b01, 8'd70, 8'd70, 7'd10);
    for (int j = 0; j < 320; j++) begin
      ep = 1'b0; ex = 0; ey = 0;
      if (j >= 1 && j <= 128) begin
        k = j - 1; ep = 1'b1; ex = 50 + k % 16; ey = 10 + k / 16;
      end else if (j >= 132 && j <= 259) begin
        k = j - 132; ep = 1'b1; ex = 70 + k % 16; ey = 10 + k / 16;
      end
      if (cap_plot[j] !== ep) bad++;
      else if (ep && (cap_x[j] !== 8'(ex) || cap_y[j] !== 7'(ey) || cap_col[j] !== 3'b110)) bad++;
      if (cap_plot[j]) plots++;
      if (cap_done[j]) dones++;
    end
    total++; if (plots != 256) $display("FAIL skip_plot_count: got %0d want 256", plots); else passed++;
    total++; if (bad != 0) $display("FAIL skip_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (cap_done[129] !== 1'b1 || cap_done[260] !== 1'b1)
      $display("FAIL skip_done_time: got %0b/%0b want 1/1", cap_done[129], cap_done[260]); else passed++;
    total++; if (dones != 2) $display("FAIL pending_done_count: got %0d want 2", dones); else passed++;
    total++; if (cap_busy[130] !== 1'b0) $display("FAIL pending_idle_gap: got %0b want 0", cap_busy[130]); else passed++;
    $display("test_same_x_pending: %0d plots, %0d done pulses", plots, dones);
  endtask

  task automatic test_clip();
    int bad = 0, plots = 0, k, c;
    logic ep;
    prev_x = 8'd150; x = 8'd150; y = 7'd20;
    capture(140, 0, -1, -1, -1, -1, 2'b01, 8'd150, 8'd150, 7'd20);
    for (int j = 0; j < 140; j++) begin
      ep = 1'b0; c = 0; k = 0;
      if (j >= 1 && j <= 128) begin
        k = j - 1; c = k % 16; ep = (150 + c < 160);
      end
      if (cap_plot[j] !== ep) bad++;
      else if (ep && (cap_x[j] !== 8'(150 + c) || cap_y[j] !== 7'(20 + k / 16))) bad++;
      if (cap_plot[j]) plots++;
    end
    total++; if (plots != 80) $display("FAIL clip_count: got %0d want 80", plots); else passed++;
    total++; if (bad != 0) $display("FAIL clip_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (cap_done[129] !== 1'b1) $display("FAIL clip_done_time: got %0b want 1", cap_done[129]); else passed++;
    $display("test_clip: %0d visible plots", plots);
  endtask

  task automatic test_over_preempt();
    int bad = 0, draws = 0, clears = 0, late = 0, dones = 0, k;
    prev_x = 8'd30; x = 8'd30; y = 7'd40;
    capture(19300, 0, 10, -1, -1, 50, 2'b10, 8'd30, 8'd30, 7'd40);
    for (int j = 0; j < 19300; j++) begin
      if (cap_done[j]) dones++;
      if (cap_plot[j]) begin
        if (j < 50) begin
          if (cap_col[j] === 3'b110) draws++;
        end else if (j >= 51 && j <= 19250) begin
          k = j - 51;
          if (cap_x[j] !== 8'(k % 160) || cap_y[j] !== 7'(k / 160) || cap_col[j] !== 3'b100) bad++;
          clears++;
        end else late++;
      end
    end
    total++; if (cap_plot[49] !== 1'b1 || cap_plot[50] !== 1'b0)
      $display("FAIL preempt_abort: got %0b%0b want 10", cap_plot[49], cap_plot[50]); else passed++;
    total++; if (draws != 49) $display("FAIL preempt_draws: got %0d want 49", draws); else passed++;
    total++; if (clears != 19200) $display("FAIL over_clear_count: got %0d want 19200", clears); else passed++;
    total++; if (bad != 0) $display("FAIL over_clear_pixels: got %0d bad want 0", bad); else passed++;
    total++; if (late != 0) $display("FAIL over_late_plots: got %0d want 0", late); else passed++;
    total++; if (dones != 0) $display("FAIL over_done: got %0d want 0", dones); else passed++;
    $display("test_over_preempt: %0d draw plots then %0d clear plots", draws, clears);
  endtask

  task automatic test_ignore_sync();
    int act = 0;
    capture(20, 2, 5, -1, -1, -1, 2'b10, 8'd10, 8'd0, 7'd0);
    for (int j = 0; j < 20; j++) if (cap_plot[j] || cap_busy[j]) act++;
    total++; if (act != 0) $display("FAIL ignore_sync: got %0d active cycles want 0", act); else passed++;
    $display("test_ignore_sync: status 10");
  endtask

  task automatic test_reset_mid();
    int act = 0;
    capture(100, -1, -1, -1, -1, 0, 2'b01, 8'd0, 8'd0, 7'd0);
    total++; if (cap_plot[99] !== 1'b1) $display("FAIL mid_sweep_running: got %0b want 1", cap_plot[99]); else passed++;
    resetn = 1'b0; game_status = 2'b00;
    tick();
    total++; if (plot !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_abort: got plot %0b busy %0b want 0 0", plot, busy); else passed++;
    resetn = 1'b1;
    capture(10, -1, -1, -1, -1, -1, 2'b00, 8'd0, 8'd0, 7'd0);
    for (int j = 0; j < 10; j++) if (cap_plot[j] || cap_busy[j]) act++;
    total++; if (act != 0) $display("FAIL reset_idle_after: got %0d active cycles want 0", act); else passed++;
    $display("test_reset_mid: aborted clear");
  endtask

  initial begin
    test_reset();
    test_clear_start();
    test_move();
    test_same_x_pending();
    test_clip();
    test_over_preempt();
    test_ignore_sync();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/block_renderer.md
# block_renderer

Downstream stage of the gameplay logic: converts the logic's block position and status outputs into a stream of single-pixel writes for the 160x120, 3-bit-colour VGA adapter. On each `sync` pulse it erases the block at its previous column and draws it at its current column. On game-status changes it clears the full screen. It is the only writer of the frame buffer.

## Interface
- `BLOCK_W`, 16, block width in pixels
- `BLOCK_H`, 8, block height in pixels
- `SCREEN_W`, 160, visible width
- `SCREEN_H`, 120, visible height
- `BG_COLOUR`, 3'b000, background colour
- `BLOCK_COLOUR`, 3'b110, block colour
- `OVER_COLOUR`, 3'b100, game-over fill colour
- `clk` in 1: 50 MHz system clock
- `resetn` in 1: synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `sync` in 1: one-cycle pulse, new position valid
- `x` in 8: current block column (top-left)
- `prev_x` in 8: previous block column
- `y` in 7: block row (top-left)
- `score` in 4: player score (used only with HUD)
- `game_status` in 2: 00 START, 01 PLAYING, 10 GAME_OVER, 11 reserved (treated as START)
- `vga_x` out 8: pixel column
- `vga_y` out 7: pixel row
- `colour` out 3: pixel colour
- `plot` out 1: write strobe, one pixel per high cycle
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse when an erase/draw sequence completes

## Operation
- States: IDLE, ERASE, DRAW, HUD (macro only), CLEAR, DONE.
- IDLE → ERASE on an accepted `sync` with `game_status`==01. ERASE sweeps BLOCK_W×BLOCK_H at (`prev_x`,`y`) with BG_COLOUR, row-major (column fastest). DRAW then sweeps the same area at (`x`,`y`) with BLOCK_COLOUR. The sequence then goes → HUD (if enabled) → DONE → IDLE.
- If `prev_x`==`x` at acceptance, ERASE is skipped.
- `x`, `prev_x`, `y` are captured into internal registers at acceptance. Input changes during a sequence have no effect.
- `sync` during ERASE/DRAW/HUD/DONE sets a one-deep `pending` flag; further pulses collapse into it. On return to IDLE with `pending` set, a new sequence starts using the inputs present that cycle, and `pending` clears.
- Any change of `game_status` into 01 or into 10 (edge detected against a registered copy) preempts the current state next cycle → CLEAR. CLEAR fills SCREEN_W×SCREEN_H with BG_COLOUR (into 01) or OVER_COLOUR (into 10), clears `pending`, then goes → IDLE without a `done` pulse.
- `sync` is ignored while in CLEAR or when `game_status`≠01.
- Clipping: pixel column = base + col, computed 9-bit. Row = base + row, computed 8-bit. If column ≥ SCREEN_W or row ≥ SCREEN_H, `plot` stays low for that cycle, but the sweep still advances.

## Timing
- Reset: state IDLE. `vga_x`=0, `vga_y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0. `pending`=0. Status register=00.
- Reset asserted mid-sweep aborts on that edge. `plot` is 0 from the next cycle.
- All outputs are registered.
- `sync` sampled high at edge N → state ERASE from N+1 → first `plot` high at N+2.
- ERASE and DRAW each take BLOCK_W·BLOCK_H cycles (128 at defaults), back-to-back with no gap. Full erase+draw = 256 plot cycles.
- `done` is high exactly one cycle, the cycle after the last DRAW/HUD plot. IDLE follows in the next cycle.
- CLEAR takes SCREEN_W·SCREEN_H = 19200 cycles.
- `busy` rises in the cycle ERASE/CLEAR is entered and falls on IDLE entry.

## Configuration
- `BLOCK_RENDERER_HUD_EN` defined: adds the HUD state after DRAW. HUD draws a 60×2 bar at (0,0): columns < 4·`score` use 3'b010, the rest use BG_COLOUR. This adds 120 cycles.
- Undefined: HUD state and `score` logic are absent. DRAW → DONE directly. `score` is unused.

## Structure
- Package `render_pkg`: state enum, `game_status` encodings, SCREEN_W/H, colour constants, HUD geometry.
- Sub-module `rect_scanner`: loadable width/height, col/row counters, `last` flag, `start`/`abort`. It is shared by ERASE, DRAW, HUD and CLEAR.

## Test plan
- Reset, then status 00→01: CLEAR with 19200 plots of colour 000; `busy` high throughout; no `done`.
- status 01, `prev_x`=20, `x`=24, `y`=100, `sync`: 128 plots of 000 over x20–35/y100–107, then 128 plots of 110 over x24–39; `done` pulse one cycle later; first plot 2 cycles after `sync`.
- `x`=`prev_x`=50, `sync`: only 128 DRAW plots; three extra `sync` pulses mid-draw → exactly one further sequence.
- `x`=150, `sync`: columns 160–165 produce no `plot`; sweep still takes 128 cycles.
- Mid-DRAW, status 01→10: plotting aborts next cycle; CLEAR with 19200 plots of 100; pending `sync` discarded.
- With HUD_EN, `score`=5: after DRAW, row 0–1 columns 0–19 are 010 and 20–59 are 000; `done` follows the 120th HUD plot.
